// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by store decode and the store unit:
// store function codes, store FSM state type and an address helper.
package riscv_pkg;

    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } store_state_t;

    // Clear the byte-offset bits so the memory port always sees a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_lane_steer.sv
// Combinational byte-lane steering for SB/SH/SW: derives byte enables,
// replicated write data and the alignment fault from the low address bits.
module store_lane_steer
    import riscv_pkg::*;
(
    input  logic [1:0]  i_ea_lo,
    input  logic [2:0]  i_store_control,
    input  logic [31:0] i_rs2_val,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    // Select lanes by access size; unknown codes fall back to byte stores.
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0000_0000;
        o_misaligned = 1'b0;
        case (i_store_control)
            SH: begin
                o_misaligned = i_ea_lo[0];
                o_be         = i_ea_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_rs2_val[15:0]}};
            end
            SW: begin
                o_misaligned = (i_ea_lo != 2'b00);
                o_be         = 4'b1111;
                o_wdata      = i_rs2_val;
            end
            default: begin
                o_misaligned = 1'b0;
                o_be         = 4'b0001 << i_ea_lo;
                o_wdata      = {4{i_rs2_val[7:0]}};
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// RISC-V store execution unit: computes the effective address, steers the
// byte lanes, and runs one req/gnt/ack write transaction at a time with an
// ack timeout. All outputs except st_ready are registered.
module store_unit
    import riscv_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [11:0] imm,
    input  logic [2:0]  store_control,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_misaligned,
    output logic        st_err,
    output logic [31:0] st_bad_addr
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    store_state_t     r_state;
    store_state_t     w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic             r_st_done;
    logic             r_st_misaligned;
    logic             r_st_err;
    logic [31:0]      r_st_bad_addr;

    logic [31:0]      w_ea;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_misaligned;
    logic             w_capture;
    logic             w_req_next;
    logic             w_done_next;
    logic             w_mis_next;
    logic             w_err_next;

    // Base plus sign-extended offset, wrapping modulo 2^32.
    assign w_ea = rs1_val + {{20{imm[11]}}, imm};

    store_lane_steer u_steer (
        .i_ea_lo         (w_ea[1:0]),
        .i_store_control (store_control),
        .i_rs2_val       (rs2_val),
        .o_be            (w_be),
        .o_wdata         (w_wdata),
        .o_misaligned    (w_misaligned)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic plus the next values of the registered outputs.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_req_next   = 1'b0;
        w_done_next  = 1'b0;
        w_mis_next   = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (st_valid) begin
                    w_capture = 1'b1;
                    if (w_misaligned) begin
                        w_state_next = RESP;
                        w_done_next  = 1'b1;
                        w_mis_next   = 1'b1;
                    end else begin
                        w_state_next = REQ;
                        w_req_next   = 1'b1;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            REQ: begin
                // An ack without a grant is not meaningful and is ignored.
                if (mem_gnt && mem_ack) begin
                    w_state_next = RESP;
                    w_done_next  = 1'b1;
                end else if (mem_gnt) begin
                    w_state_next = WAIT_ACK;
                    w_cnt_next   = CNT_ZERO;
                end else begin
                    w_req_next   = 1'b1;
                end
            end
            WAIT_ACK: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (mem_ack) begin
                    w_state_next = RESP;
                    w_done_next  = 1'b1;
                end else if (r_cnt == CNT_LIMIT) begin
                    w_state_next = RESP;
                    w_done_next  = 1'b1;
                    w_err_next   = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered outputs; transaction fields are frozen at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req       <= 1'b0;
            r_mem_addr      <= 32'h0000_0000;
            r_mem_wdata     <= 32'h0000_0000;
            r_mem_be        <= 4'b0000;
            r_st_done       <= 1'b0;
            r_st_misaligned <= 1'b0;
            r_st_err        <= 1'b0;
            r_st_bad_addr   <= 32'h0000_0000;
        end else begin
            r_mem_req       <= w_req_next;
            r_st_done       <= w_done_next;
            r_st_misaligned <= w_mis_next;
            r_st_err        <= w_err_next;
            if (w_capture) begin
                r_mem_addr    <= word_align(w_ea);
                r_mem_wdata   <= w_wdata;
                r_mem_be      <= w_be;
                r_st_bad_addr <= w_ea;
            end else begin
                r_mem_addr    <= r_mem_addr;
                r_mem_wdata   <= r_mem_wdata;
                r_mem_be      <= r_mem_be;
                r_st_bad_addr <= r_st_bad_addr;
            end
        end
    end

    assign st_ready      = (r_state == IDLE);
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_be        = r_mem_be;
    assign st_done       = r_st_done;
    assign st_misaligned = r_st_misaligned;
    assign st_err        = r_st_err;
    assign st_bad_addr   = r_st_bad_addr;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: a table of store vectors with hand-computed
// lane/address results, plus sequences for wait states, timeout and reset.
module tb_store_unit;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [11:0] imm;
    logic [2:0]  store_control;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_ack;
    logic        st_done;
    logic        st_misaligned;
    logic        st_err;
    logic [31:0] st_bad_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_bad;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    store_unit #(.ACK_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .imm           (imm),
        .store_control (store_control),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_gnt       (mem_gnt),
        .mem_ack       (mem_ack),
        .st_done       (st_done),
        .st_misaligned (st_misaligned),
        .st_err        (st_err),
        .st_bad_addr   (st_bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] rs1,
                                input logic [11:0] im, input logic [31:0] rs2,
                                input logic mis, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] bad);
        vec_t v;
        v.ctl = ctl; v.rs1 = rs1; v.imm = im; v.rs2 = rs2; v.exp_mis = mis;
        v.exp_addr = addr; v.exp_be = be; v.exp_wdata = wd; v.exp_bad = bad;
        return v;
    endfunction

    // Present a store at a negedge; returns at the negedge of cycle 1.
    task automatic offer(input vec_t v);
        store_control = v.ctl;
        rs1_val       = v.rs1;
        rs2_val       = v.rs2;
        imm           = v.imm;
        st_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st_valid      = 1'b0;
    endtask

    // Full store: gnt after gnt_wait cycles (spurious acks during that wait),
    // ack ack_wait cycles after the grant. Starts and ends at a negedge.
    task automatic run_store(input string tag, input vec_t v,
                             input int gnt_wait, input int ack_wait);
        logic bad_hold;
        logic early;
        chk({tag, "_ready"}, {31'd0, st_ready}, 32'd1);
        offer(v);
        if (v.exp_mis) begin
            chk({tag, "_done"}, {31'd0, st_done}, 32'd1);
            chk({tag, "_mis"}, {31'd0, st_misaligned}, 32'd1);
            chk({tag, "_err"}, {31'd0, st_err}, 32'd0);
            chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
            chk({tag, "_bad"}, st_bad_addr, v.exp_bad);
        end else begin
            chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_addr"}, mem_addr, v.exp_addr);
            chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
            chk({tag, "_wdata"}, mem_wdata, v.exp_wdata);
            bad_hold = 1'b0;
            for (int i = 0; i < gnt_wait; i++) begin
                mem_gnt = 1'b0;
                mem_ack = 1'b1;
                @(negedge clk);
                if (mem_req !== 1'b1 || mem_addr !== v.exp_addr ||
                    mem_wdata !== v.exp_wdata || mem_be !== v.exp_be ||
                    st_done !== 1'b0)
                    bad_hold = 1'b1;
            end
            if (gnt_wait > 0) chk({tag, "_hold"}, {31'd0, bad_hold}, 32'd0);
            mem_gnt = 1'b1;
            mem_ack = (ack_wait == 0);
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_ack = 1'b0;
            if (ack_wait > 0) begin
                early = 1'b0;
                for (int i = 1; i < ack_wait; i++) begin
                    if (st_done !== 1'b0) early = 1'b1;
                    @(negedge clk);
                end
                if (st_done !== 1'b0) early = 1'b1;
                chk({tag, "_early"}, {31'd0, early}, 32'd0);
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end
            chk({tag, "_done"}, {31'd0, st_done}, 32'd1);
            chk({tag, "_flags"}, {30'd0, st_misaligned, st_err}, 32'd0);
            chk({tag, "_bad"}, st_bad_addr, v.exp_bad);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, st_done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, st_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        logic seen;

        vecs[0]  = mk(3'd2, 32'h0000_1000, 12'h004, 32'hDEAD_BEEF, 1'b0, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1004);
        vecs[1]  = mk(3'd0, 32'h0000_2003, 12'hFFF, 32'h1234_5678, 1'b0, 32'h0000_2000, 4'b0100, 32'h7878_7878, 32'h0000_2002);
        vecs[2]  = mk(3'd1, 32'h0000_3000, 12'h001, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_3001);
        vecs[3]  = mk(3'd2, 32'h0000_3000, 12'h002, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_3002);
        vecs[4]  = mk(3'd1, 32'h0000_4000, 12'h002, 32'hAAAA_5678, 1'b0, 32'h0000_4000, 4'b1100, 32'h5678_5678, 32'h0000_4002);
        vecs[5]  = mk(3'd1, 32'h0000_5000, 12'h000, 32'h0000_BEEF, 1'b0, 32'h0000_5000, 4'b0011, 32'hBEEF_BEEF, 32'h0000_5000);
        vecs[6]  = mk(3'd7, 32'h0000_6000, 12'h001, 32'h0000_00A5, 1'b0, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_6001);
        vecs[7]  = mk(3'd0, 32'h0000_7000, 12'h003, 32'h0000_0011, 1'b0, 32'h0000_7000, 4'b1000, 32'h1111_1111, 32'h0000_7003);
        vecs[8]  = mk(3'd2, 32'h0000_0004, 12'h800, 32'hCAFE_F00D, 1'b0, 32'hFFFF_F804, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_F804);
        vecs[9]  = mk(3'd3, 32'hFFFF_FFFF, 12'h001, 32'h0000_003C, 1'b0, 32'h0000_0000, 4'b0001, 32'h3C3C_3C3C, 32'h0000_0000);
        vecs[10] = mk(3'd2, 32'h0000_0001, 12'h7FF, 32'h0102_0304, 1'b0, 32'h0000_0800, 4'b1111, 32'h0102_0304, 32'h0000_0800);

        rst = 1'b1; st_valid = 1'b0; rs1_val = 32'd0; rs2_val = 32'd0;
        imm = 12'd0; store_control = 3'd0; mem_gnt = 1'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done_flags", {29'd0, st_done, st_misaligned, st_err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_bad", st_bad_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, st_ready}, 32'd1);

        // Table: zero-wait memory, back-to-back issue.
        for (int i = 0; i < NVEC; i++)
            run_store($sformatf("v%0d", i), vecs[i], 0, 0);

        // Grant held off 5 cycles, ack 3 cycles after grant.
        run_store("slow", vecs[0], 5, 3);
        // Grant at once, ack one cycle later.
        run_store("ack1", vecs[4], 0, 1);

        // Ack never returns: error 16 cycles after the grant.
        offer(vecs[6]);
        chk("to_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (st_done !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk("to_early", {31'd0, seen}, 32'd0);
        chk("to_done", {31'd0, st_done}, 32'd1);
        chk("to_err", {31'd0, st_err}, 32'd1);
        chk("to_mis", {31'd0, st_misaligned}, 32'd0);
        chk("to_bad", st_bad_addr, 32'h0000_6001);
        @(negedge clk);
        chk("to_pulse", {31'd0, st_done}, 32'd0);
        chk("to_idle", {31'd0, st_ready}, 32'd1);

        // Reset while requesting: mem_req drops without waiting for a clock.
        offer(vecs[0]);
        chk("rreq_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rreq_req_async", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for ack: no st_done for the aborted store.
        @(negedge clk);
        offer(vecs[10]);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rwait_req", {31'd0, mem_req}, 32'd0);
        chk("rwait_ready", {31'd0, st_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 0);
            @(negedge clk);
            if (st_done !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
        end
        mem_ack = 1'b0;
        chk("rwait_no_done", {31'd0, seen}, 32'd0);
        run_store("post_rst", vecs[0], 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Memory-side execution block for RISC-V store instructions (SB/SH/SW). Consumes the fields produced by store decode (`rs1`/`rs2` operand values, 12-bit immediate, `store_control`) together with register-file read data. Computes the effective address, performs lane steering and alignment checks, and runs a request/grant/acknowledge transaction on the data-memory write port. Sits between the execute stage and data memory and handles one store at a time.

## Interface
Parameters:
- ACK_TIMEOUT, 16: maximum cycles spent waiting for `mem_ack` after grant before aborting with an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- st_valid  in  1  a store is offered.
- st_ready  out  1  unit can accept a store.
- rs1_val  in  32  base register value.
- rs2_val  in  32  store data register value.
- imm  in  12  signed offset from store decode.
- store_control  in  3  SB/SH/SW code; any other value is treated as SB.
- mem_req  out  1  write request to data memory.
- mem_addr  out  32  word-aligned address, with bits [1:0] = 0.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  memory accepts the request.
- mem_ack  in  1  write is complete.
- st_done  out  1  one-cycle pulse: store retired (ok or error).
- st_misaligned  out  1  qualifies `st_done`: alignment fault, no memory access made.
- st_err  out  1  qualifies `st_done`: ack timeout.
- st_bad_addr  out  32  effective address; valid when `st_done` is high.

## Operation
- Effective address: ea = rs1_val + sign-extended imm, modulo 2^32.
- SB: mem_be = 4'b0001 << ea[1:0]; mem_wdata = {4{rs2_val[7:0]}}.
- SH:
  - Alignment fault if ea[0] = 1.
  - mem_be = 4'b1100 if ea[1] = 1, else 4'b0011.
  - mem_wdata = {2{rs2_val[15:0]}}.
- SW: alignment fault if ea[1:0] ≠ 0; mem_be = 4'b1111; mem_wdata = rs2_val.
- FSM states: IDLE, REQ, WAIT_ACK, RESP.
  - IDLE: st_ready = 1. On st_valid, capture ea, be and wdata into registers.
    - Alignment fault → RESP with misaligned flag set.
    - Otherwise → REQ.
  - REQ: mem_req = 1, outputs held stable.
    - mem_gnt & mem_ack → RESP.
    - mem_gnt only → WAIT_ACK and clear the timeout counter.
    - mem_ack without mem_gnt is ignored.
  - WAIT_ACK: counter increments each cycle.
    - mem_ack → RESP (ok).
    - Counter reaches ACK_TIMEOUT−1 without ack → RESP with error flag set.
    - If ack arrives in the same cycle the limit is reached, ack wins.
  - RESP: st_done = 1 for exactly one cycle, with st_misaligned, st_err and st_bad_addr valid; then → IDLE.
- Outputs are registered, not combinational from inputs (except st_ready, which decodes the state).

## Timing
- Reset values: state IDLE.
  - mem_req, st_done, st_misaligned, st_err = 0; mem_addr, mem_wdata, mem_be, st_bad_addr = 0.
  - st_ready = 1 once out of reset.
- Assertion of rst at any point, including mid-transaction, forces IDLE immediately. mem_req drops asynchronously; no st_done is produced for the aborted store.
- Accept edge = cycle 0. Earliest mem_req is cycle 1. Zero-wait memory (gnt and ack in cycle 1) gives st_done in cycle 2.
- Misaligned store: st_done plus st_misaligned in cycle 1; mem_req never asserts.
- Back-to-back throughput: the next store is accepted in the cycle after RESP, so at best one store per 3 cycles.
- The memory side may hold mem_gnt low indefinitely; no timeout applies in REQ.

## Structure
- Shared package `riscv_pkg` holds:
  - store codes SB = 3'd0, SH = 3'd1, SW = 3'd2, used by both store decode and this block;
  - the state enum type `store_state_t`.
- Optional sub-module `store_lane_steer` (combinational): inputs ea[1:0], store_control, rs2_val; outputs be, wdata, misaligned. This lets the steering logic be verified on its own.

## Test plan
- SW with rs1_val = 0x1000, imm = 0x004, rs2_val = 0xDEADBEEF; gnt and ack in cycle 1 → mem_addr = 0x1004, mem_be = 1111, mem_wdata = 0xDEADBEEF, st_done in cycle 2 with no flags set.
- SB with rs1_val = 0x2003, imm = 0xFFF (−1), rs2_val = 0x12345678 → ea = 0x2002, mem_addr = 0x2000, mem_be = 0100, mem_wdata = 0x78787878.
- SH with ea = 0x3001 → st_done plus st_misaligned in cycle 1, st_bad_addr = 0x3001, mem_req stays 0. SW with ea = 0x3002 → same behaviour.
- mem_gnt held low for 5 cycles, then granted, ack 3 cycles later → mem_req stays high and stable through the wait; st_done arrives one cycle after ack.
- Grant with ack never returned, ACK_TIMEOUT = 16 → st_done plus st_err 16 cycles after grant; unit returns to IDLE. Also check that store_control = 3'd7 behaves as SB.
- rst asserted in WAIT_ACK → mem_req goes to 0 immediately with no st_done. After reset releases, st_ready = 1 and a new SW completes normally.
